conv2d_layer_ctrl: RTL and testbench

Layer sequencer for the `Conv2d` engine. It accepts weights, biases and an input feature map as a narrow word stream and assembles them into the engine's packed operand buses. It then runs the engine by holding `clken` until `result_valid_out`, and drains the captured result map as a valid/ready word stream. It sits between the layer DMA/loader and the next layer (pool/activation) in the `simple_CNN` pipeline.

---
 rtl/conv2d_layer_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_conv2d_layer_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_layer_ctrl.sv
// conv2d_layer_ctrl
//
// Layer sequencer for the Conv2d engine. It assembles weights, biases and an input feature map
// from a narrow load stream into the engine's packed operand buses. It then runs the engine
// until a result is flagged and drains the captured result map as a valid/ready word stream.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   start, reuse_w           run request (sampled in IDLE); reuse_w skips the weight/bias load
//   busy, done, error        status: not-idle level, end-of-drain pulse, RUN-timeout pulse
//   ld_valid/ld_ready/ld_data   load word stream (weights, then biases, then data)
//   conv_clken               engine enable, high for the whole of RUN
//   conv_data/weight/bias    packed operand buses, word k at [k*BITWIDTH +: BITWIDTH]
//   conv_result, conv_valid  engine result bus and its valid flag
//   res_valid/res_ready/res_data/res_last   result word stream, 2*BITWIDTH per word

module conv2d_layer_ctrl #(
    parameter int unsigned BITWIDTH     = 8,
    parameter int unsigned DATA_WORDS   = 64,
    parameter int unsigned WEIGHT_WORDS = 144,
    parameter int unsigned BIAS_WORDS   = 16,
    parameter int unsigned RESULT_WORDS = 576,
    parameter int unsigned TIMEOUT      = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 reuse_w,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    input  logic                                 ld_valid,
    output logic                                 ld_ready,
    input  logic [BITWIDTH-1:0]                  ld_data,
    output logic                                 conv_clken,
    output logic [BITWIDTH*DATA_WORDS-1:0]       conv_data,
    output logic [BITWIDTH*WEIGHT_WORDS-1:0]     conv_weight,
    output logic [BITWIDTH*BIAS_WORDS-1:0]       conv_bias,
    input  logic [2*BITWIDTH*RESULT_WORDS-1:0]   conv_result,
    input  logic                                 conv_valid,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [2*BITWIDTH-1:0]                res_data,
    output logic                                 res_last
);

    localparam int unsigned WB_WORDS = WEIGHT_WORDS + BIAS_WORDS;
    localparam int unsigned LD_MAX   = (WB_WORDS > DATA_WORDS) ? WB_WORDS : DATA_WORDS;
    localparam int unsigned LD_W     = $clog2(LD_MAX);
    localparam int unsigned RES_W    = $clog2(RESULT_WORDS);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned RW       = 2 * BITWIDTH;

    typedef enum logic [2:0] {StIdle, StLoadW, StLoadD, StRun, StDrain} state_e;

    state_e                              r_state, w_state_nxt;
    logic [LD_W-1:0]                     r_ld_idx, w_ld_idx_nxt;
    logic [RES_W-1:0]                    r_res_idx, w_res_idx_nxt;
    logic [TMO_W-1:0]                    r_tmo, w_tmo_nxt;
    logic                                r_done, w_done_nxt;
    logic                                r_error, w_error_nxt;
    logic [BITWIDTH*WEIGHT_WORDS-1:0]    r_weight;
    logic [BITWIDTH*BIAS_WORDS-1:0]      r_bias;
    logic [BITWIDTH*DATA_WORDS-1:0]      r_data;
    logic [RW*RESULT_WORDS-1:0]          r_result;
    logic [LD_W-1:0]                     w_bias_idx;
    logic                                w_ld_fire;
    logic                                w_res_last;

    assign w_ld_fire  = ld_valid && ld_ready;
    assign w_bias_idx = r_ld_idx - LD_W'(WEIGHT_WORDS);
    assign w_res_last = (r_res_idx == RES_W'(RESULT_WORDS - 1));

    // Outputs decode straight from state so reset drops them without waiting for a clock.
    assign busy        = (r_state != StIdle);
    assign ld_ready    = (r_state == StLoadW) || (r_state == StLoadD);
    assign conv_clken  = (r_state == StRun);
    assign res_valid   = (r_state == StDrain);
    assign res_last    = (r_state == StDrain) && w_res_last;
    assign res_data    = r_result[r_res_idx*RW +: RW];
    assign done        = r_done;
    assign error       = r_error;
    assign conv_weight = r_weight;
    assign conv_bias   = r_bias;
    assign conv_data   = r_data;

    always_comb begin
        w_state_nxt   = r_state;
        w_ld_idx_nxt  = r_ld_idx;
        w_res_idx_nxt = r_res_idx;
        w_tmo_nxt     = r_tmo;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt  = reuse_w ? StLoadD : StLoadW;
                    w_ld_idx_nxt = '0;
                end
            end
            StLoadW: begin
                if (ld_valid) begin
                    if (r_ld_idx == LD_W'(WB_WORDS - 1)) begin
                        w_state_nxt  = StLoadD;
                        w_ld_idx_nxt = '0;
                    end else begin
                        w_ld_idx_nxt = r_ld_idx + 1'b1;
                    end
                end
            end
            StLoadD: begin
                if (ld_valid) begin
                    if (r_ld_idx == LD_W'(DATA_WORDS - 1)) begin
                        w_state_nxt  = StRun;
                        w_ld_idx_nxt = '0;
                        w_tmo_nxt    = '0;
                    end else begin
                        w_ld_idx_nxt = r_ld_idx + 1'b1;
                    end
                end
            end
            StRun: begin
                if (conv_valid) begin
                    w_state_nxt   = StDrain;
                    w_res_idx_nxt = '0;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th RUN cycle without a result.
                    w_state_nxt = StIdle;
                    w_error_nxt = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            StDrain: begin
                if (res_ready) begin
                    if (w_res_last) begin
                        w_state_nxt   = StIdle;
                        w_done_nxt    = 1'b1;
                        w_res_idx_nxt = '0;
                    end else begin
                        w_res_idx_nxt = r_res_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_ld_idx  <= '0;
            r_res_idx <= '0;
            r_tmo     <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ld_idx  <= w_ld_idx_nxt;
            r_res_idx <= w_res_idx_nxt;
            r_tmo     <= w_tmo_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    // Operand and result storage. Weights/biases are only written in LOAD_W, so they survive
    // reuse runs; the result buffer only changes on the capture cycle, so a timeout leaves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weight <= '0;
            r_bias   <= '0;
            r_data   <= '0;
            r_result <= '0;
        end else begin
            if (w_ld_fire && (r_state == StLoadW)) begin
                if (r_ld_idx < LD_W'(WEIGHT_WORDS)) begin
                    r_weight[r_ld_idx*BITWIDTH +: BITWIDTH] <= ld_data;
                end else begin
                    r_bias[w_bias_idx*BITWIDTH +: BITWIDTH] <= ld_data;
                end
            end
            if (w_ld_fire && (r_state == StLoadD)) begin
                r_data[r_ld_idx*BITWIDTH +: BITWIDTH] <= ld_data;
            end
            if ((r_state == StRun) && conv_valid) begin
                r_result <= conv_result;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_layer_ctrl.sv
// tb_conv2d_layer_ctrl
//
// Bench for conv2d_layer_ctrl at default parameters. A behavioural 3x3 convolution engine
// (8x8x1 input, 16 filters, 6x6 output) stands in for Conv2d and answers a few cycles after
// conv_clken rises, unless told to hang. Expected result words come from hand-derived constants
// or from the bench's own copy of the loaded operands.

module tb_conv2d_layer_ctrl;

    localparam int BW   = 8;
    localparam int DW   = 64;
    localparam int WW   = 144;
    localparam int BWD  = 16;
    localparam int RW   = 576;
    localparam int TMO  = 4096;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 reuse_w = 1'b0;
    logic                 ld_valid = 1'b0;
    logic [BW-1:0]        ld_data = '0;
    logic                 res_ready = 1'b0;
    logic                 stray_valid = 1'b0;
    logic                 busy, done, error, ld_ready, conv_clken;
    logic                 res_valid, res_last;
    logic [2*BW-1:0]      res_data;
    logic [BW*DW-1:0]     conv_data;
    logic [BW*WW-1:0]     conv_weight;
    logic [BW*BWD-1:0]    conv_bias;
    logic [16*RW-1:0]     eng_result = '0;
    logic                 eng_valid = 1'b0;
    logic                 conv_valid;
    int                   eng_cnt = 0;
    bit                   eng_hang = 1'b0;
    int                   cyc = 0;

    logic [7:0]           wbuf [WW+BWD];
    logic [7:0]           dbuf [DW];
    logic [16*RW-1:0]     exp_bus;

    int                   n_chk = 0;
    int                   n_fail = 0;

    assign conv_valid = eng_valid | stray_valid;

    conv2d_layer_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .reuse_w     (reuse_w),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .conv_clken  (conv_clken),
        .conv_data   (conv_data),
        .conv_weight (conv_weight),
        .conv_bias   (conv_bias),
        .conv_result (eng_result),
        .conv_valid  (conv_valid),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_last    (res_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16*RW-1:0] conv_model(input logic [8*WW-1:0] w,
                                                    input logic [8*BWD-1:0] b,
                                                    input logic [8*DW-1:0] d);
        logic [16*RW-1:0] r;
        logic [15:0]      acc;
        r = '0;
        for (int f = 0; f < 16; f++) begin
            for (int oy = 0; oy < 6; oy++) begin
                for (int ox = 0; ox < 6; ox++) begin
                    acc = {8'h00, b[f*8 +: 8]};
                    for (int ky = 0; ky < 3; ky++) begin
                        for (int kx = 0; kx < 3; kx++) begin
                            acc = acc + 16'(w[(f*9 + ky*3 + kx)*8 +: 8])
                                      * 16'(d[((oy + ky)*8 + ox + kx)*8 +: 8]);
                        end
                    end
                    r[(f*36 + oy*6 + ox)*16 +: 16] = acc;
                end
            end
        end
        return r;
    endfunction

    // Engine stand-in: answers on the fourth enabled edge, holding valid until enable drops.
    always @(posedge clk) begin
        if (!conv_clken) begin
            eng_cnt   <= 0;
            eng_valid <= 1'b0;
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 3 && !eng_hang) begin
                eng_result <= conv_model(conv_weight, conv_bias, conv_data);
                eng_valid  <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({busy, done, error, ld_ready, conv_clken, res_valid, res_last}),
              32'd0);
        check({tag, "_bus"}, 32'((|conv_weight) | (|conv_bias) | (|conv_data) | (|res_data)),
              32'd0);
    endtask

    task automatic exp_const(input logic [15:0] v);
        for (int i = 0; i < RW; i++) exp_bus[i*16 +: 16] = v;
    endtask

    task automatic exp_model();
        logic [8*WW-1:0]  w;
        logic [8*BWD-1:0] b;
        logic [8*DW-1:0]  d;
        for (int k = 0; k < WW; k++)  w[k*8 +: 8] = wbuf[k];
        for (int k = 0; k < BWD; k++) b[k*8 +: 8] = wbuf[WW + k];
        for (int k = 0; k < DW; k++)  d[k*8 +: 8] = dbuf[k];
        exp_bus = conv_model(w, b, d);
    endtask

    task automatic fill_wb(input logic [7:0] wv, input logic [7:0] bv);
        for (int k = 0; k < WW + BWD; k++) wbuf[k] = (k < WW) ? wv : bv;
    endtask

    task automatic fill_d(input logic [7:0] dv);
        for (int k = 0; k < DW; k++) dbuf[k] = dv;
    endtask

    task automatic do_start(input bit reuse);
        @(negedge clk);
        start   = 1'b1;
        reuse_w = reuse;
        @(negedge clk);
        start   = 1'b0;
        reuse_w = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_ld_ready", 32'(ld_ready), 32'd1);
    endtask

    // Streams n words; gap>1 offers a word only every gap-th cycle. Returns with the bench at
    // the negedge after the last accepted word; t_acc is that word's cycle number.
    task automatic load_stream(input bit is_w, input int n, input int gap, input bit pulse_start,
                               output int t_acc);
        int k = 0;
        int t = 0;
        t_acc = -1;
        while (k < n && t < 20*n + 100) begin
            ld_valid = ((t % gap) == 0);
            ld_data  = is_w ? wbuf[k] : dbuf[k];
            start    = pulse_start && (k == n/2);
            if (ld_valid && ld_ready) begin
                t_acc = cyc;
                k++;
            end
            @(negedge clk);
            t++;
        end
        ld_valid = 1'b0;
        start    = 1'b0;
        check(is_w ? "load_w_count" : "load_d_count", 32'(k), 32'(n));
    endtask

    task automatic load_d_and_run(input int gap, input bit pulse_start);
        int t_acc;
        load_stream(1'b0, DW, gap, pulse_start, t_acc);
        check("run_clken", 32'(conv_clken), 32'd1);
        check("run_ld_ready", 32'(ld_ready), 32'd0);
        check("run_entry_cycle", 32'(cyc - t_acc), 32'd1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (!res_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_entry", 32'(res_valid), 32'd1);
        check("drain_clken_off", 32'(conv_clken), 32'd0);
    endtask

    task automatic drain(input bit rnd, input int stop_at, input bit pulse_start);
        int          i = 0;
        int          t = 0;
        bit          stalled = 1'b0;
        logic [16:0] held = '0;
        while (i < RW && i != stop_at && t < 10000) begin
            if (!res_valid) begin
                check("drain_valid_held", 32'(res_valid), 32'd1);
                break;
            end
            if (stalled) begin
                check($sformatf("stall_hold[%0d]", i), 32'({res_last, res_data}), 32'(held));
            end else begin
                check($sformatf("res_word[%0d]", i), 32'(res_data), 32'(exp_bus[i*16 +: 16]));
                check($sformatf("res_last[%0d]", i), 32'(res_last), 32'(i == RW - 1));
            end
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = pulse_start && (i == 10);
            held      = {res_last, res_data};
            stalled   = !res_ready;
            if (res_ready) i++;
            @(negedge clk);
            t++;
        end
        res_ready = 1'b0;
        start     = 1'b0;
    endtask

    task automatic finish_drain();
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int t_acc;
        int err_cyc;
        int n_err;
        int n_done;
        int n_resv;
        logic busy_at_err;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Stray engine valid in IDLE must not start anything
        stray_valid = 1'b1;
        repeat (2) @(negedge clk);
        stray_valid = 1'b0;
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_res_valid", 32'(res_valid), 32'd0);

        // Run A: weights 1, bias 0, data 1 -> 9; start pulsed during DRAIN
        fill_wb(8'd1, 8'd0);
        fill_d(8'd1);
        exp_const(16'h0009);
        do_start(1'b0);
        load_stream(1'b1, WW + BWD, 1, 1'b0, t_acc);
        check("wpack", 32'(conv_weight == {WW{8'h01}}), 32'd1);
        check("bpack", 32'(conv_bias), 32'd0);
        load_d_and_run(1, 1'b0);
        wait_drain();
        drain(1'b0, -1, 1'b1);
        finish_drain();

        // Run B: reuse weights, data 2 -> 0x12; start pulsed during LOAD_D
        fill_d(8'd2);
        exp_const(16'h0012);
        do_start(1'b1);
        load_d_and_run(1, 1'b1);
        wait_drain();
        drain(1'b0, -1, 1'b0);
        finish_drain();

        // Run C: full reload with bias 5, data 1 -> 0x0E
        fill_wb(8'd1, 8'd5);
        fill_d(8'd1);
        exp_const(16'h000E);
        do_start(1'b0);
        load_stream(1'b1, WW + BWD, 1, 1'b0, t_acc);
        load_d_and_run(1, 1'b0);
        wait_drain();
        drain(1'b0, -1, 1'b0);
        finish_drain();

        // Run D: varied operands, sparse load, random ready
        for (int k = 0; k < WW; k++)  wbuf[k] = 8'((k*7 + 3) % 11);
        for (int k = 0; k < BWD; k++) wbuf[WW + k] = 8'((k*3) % 13);
        for (int k = 0; k < DW; k++)  dbuf[k] = 8'((k*5 + 1) % 9);
        exp_model();
        do_start(1'b0);
        load_stream(1'b1, WW + BWD, 3, 1'b0, t_acc);
        load_d_and_run(3, 1'b0);
        wait_drain();
        drain(1'b1, -1, 1'b0);
        finish_drain();

        // Timeout: engine never answers
        eng_hang = 1'b1;
        do_start(1'b1);
        load_stream(1'b0, DW, 1, 1'b0, t_acc);
        err_cyc = -1;
        n_err = 0;
        n_done = 0;
        n_resv = 0;
        busy_at_err = 1'b1;
        for (int j = 0; j < TMO + 20; j++) begin
            if (error) begin
                n_err++;
                if (err_cyc < 0) begin
                    err_cyc = cyc;
                    busy_at_err = busy;
                end
            end
            if (done) n_done++;
            if (res_valid) n_resv++;
            @(negedge clk);
        end
        eng_hang = 1'b0;
        check("tmo_latency", 32'(err_cyc - t_acc), 32'(TMO + 1));
        check("tmo_error_count", 32'(n_err), 32'd1);
        check("tmo_busy", 32'(busy_at_err), 32'd0);
        check("tmo_no_done", 32'(n_done), 32'd0);
        check("tmo_no_res_valid", 32'(n_resv), 32'd0);

        // Reset in the middle of DRAIN, at word 100
        fill_d(8'd1);
        exp_model();
        do_start(1'b1);
        load_d_and_run(1, 1'b0);
        wait_drain();
        drain(1'b0, 100, 1'b0);
        check("pre_rst_res_valid", 32'(res_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_drain_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh full run after reset
        fill_wb(8'd1, 8'd0);
        fill_d(8'd1);
        exp_const(16'h0009);
        do_start(1'b0);
        load_stream(1'b1, WW + BWD, 1, 1'b0, t_acc);
        load_d_and_run(1, 1'b0);
        wait_drain();
        drain(1'b0, -1, 1'b0);
        finish_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
